chnl_tx_drain: RTL and testbench

Transmit-side drain engine for the host channel on the ML605 board: pulls a commanded number of beats from a deep FIFO's val/rdy output and delivers them to the host as one RIFFA channel TX transaction. It is the consumer end of the FIFO chain; the deep FIFO buffers captured data, and this block empties it toward the PC. Per command it runs exactly one transaction, with `CHNL_TX_LEN` derived from the command length.

---
 rtl/chnl_pkg.sv | 20 ++
 rtl/tx_skid.sv | 73 +++++++
 rtl/chnl_tx_drain.sv | 159 +++++++++++++++
 tb/tb_chnl_tx_drain.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chnl_pkg.sv
// chnl_pkg: shared definitions for the host-channel TX drain engine.
//   tx_state_t      - drain FSM states (IDLE/REQ/XFER)
//   RIFFA_WORD_W    - RIFFA length unit, in bits
//   words_per_beat  - number of 32-bit RIFFA words carried by one data beat
package chnl_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_XFER = 2'd2
  } tx_state_t;

  localparam int unsigned RIFFA_WORD_W = 32'd32;

  // Channel length is counted in 32-bit words, the FIFO in beats.
  function automatic int unsigned words_per_beat(input int unsigned width);
    return width / RIFFA_WORD_W;
  endfunction

endpackage

// File: rtl/tx_skid.sv
// tx_skid: 2-entry val/rdy skid buffer with fully registered outputs.
//   clk, srst_n             - clock, synchronous active-low reset
//   in_val_i/in_rdy_o/in_data_i    - upstream side
//   out_val_o/out_rdy_i/out_data_o - downstream side (registered)
// in_rdy_o depends only on local state, so upstream ready is registered too.
module tx_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             in_val_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_val_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_val_q, out_val_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             sk_val_q, sk_val_d;
  logic [WIDTH-1:0] sk_data_q, sk_data_d;
  logic             in_fire_s;

  assign in_rdy_o   = ~sk_val_q;
  assign in_fire_s  = in_val_i & ~sk_val_q;
  assign out_val_o  = out_val_q;
  assign out_data_o = out_data_q;

  // Next-state: refill the output stage from the skid slot first, else from input.
  always_comb begin
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    sk_val_d   = sk_val_q;
    sk_data_d  = sk_data_q;
    if (!out_val_q || out_rdy_i) begin
      if (sk_val_q) begin
        out_val_d  = 1'b1;
        out_data_d = sk_data_q;
        sk_val_d   = 1'b0;
      end else if (in_fire_s) begin
        out_val_d  = 1'b1;
        out_data_d = in_data_i;
      end else begin
        out_val_d  = 1'b0;
      end
    end else begin
      // Output stalled: a beat accepted this cycle parks in the skid slot.
      if (in_fire_s) begin
        sk_val_d  = 1'b1;
        sk_data_d = in_data_i;
      end else begin
        sk_val_d  = sk_val_q;
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      sk_val_q   <= 1'b0;
      sk_data_q  <= '0;
    end else begin
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      sk_val_q   <= sk_val_d;
      sk_data_q  <= sk_data_d;
    end
  end

endmodule

// File: rtl/chnl_tx_drain.sv
// chnl_tx_drain: drains cmd_len beats from an upstream FIFO (val/rdy) into one
// RIFFA channel TX transaction per accepted command.
//   clk, srst_n                 - clock, synchronous active-low reset
//   cmd_val/cmd_rdy/cmd_len     - command (length in beats; 0 = no-op)
//   i_val/i_rdy/i_data          - upstream FIFO output
//   chnl_tx/chnl_tx_ack/..._len/_off/_last - RIFFA transaction request
//   chnl_tx_data/_valid/_ren    - RIFFA data beats
//   busy                        - engine not idle
// Build option CHNL_TX_DRAIN_REG_EN: inserts tx_skid so all host-side data
// outputs are registered (one extra cycle of beat latency).
module chnl_tx_drain
  import chnl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             i_val,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             chnl_tx,
  input  logic             chnl_tx_ack,
  output logic             chnl_tx_last,
  output logic [31:0]      chnl_tx_len,
  output logic [30:0]      chnl_tx_off,
  output logic [WIDTH-1:0] chnl_tx_data,
  output logic             chnl_tx_data_valid,
  input  logic             chnl_tx_data_ren,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = TX_IDLE;
  localparam logic [1:0] ST_REQ  = TX_REQ;
  localparam logic [1:0] ST_XFER = TX_XFER;
  localparam logic [31:0] WPB = 32'(words_per_beat(WIDTH));
  localparam logic [LEN_W-1:0] ONE_BEAT = LEN_W'(1'b1);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      len_q, len_d;
  logic             in_xfer_s, cmd_fire_s, out_fire_s, out_val_s;
  logic [WIDTH-1:0] out_data_s;

  assign in_xfer_s    = (state_q == ST_XFER);
  // Gated by reset so no command can be taken while srst_n is low.
  assign cmd_rdy      = srst_n & (state_q == ST_IDLE);
  assign cmd_fire_s   = cmd_val & cmd_rdy;
  assign chnl_tx      = (state_q == ST_REQ) | (state_q == ST_XFER);
  assign busy         = (state_q != ST_IDLE);
  assign chnl_tx_last = 1'b1;
  assign chnl_tx_off  = 31'd0;
  assign chnl_tx_len  = len_q;

`ifdef CHNL_TX_DRAIN_REG_EN
  // Upstream-side beat budget: stop accepting once cmd_len beats are buffered.
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic             sk_in_rdy_s, sk_in_val_s, in_open_s;

  assign in_open_s   = in_xfer_s & (in_cnt_q != '0) & srst_n;
  assign sk_in_val_s = i_val & in_open_s;
  assign i_rdy       = sk_in_rdy_s & in_open_s;

  tx_skid #(.WIDTH(WIDTH)) u_skid (
    .clk        (clk),
    .srst_n     (srst_n),
    .in_val_i   (sk_in_val_s),
    .in_rdy_o   (sk_in_rdy_s),
    .in_data_i  (i_data),
    .out_val_o  (out_val_s),
    .out_rdy_i  (chnl_tx_data_ren),
    .out_data_o (out_data_s)
  );

  // Upstream budget next-state: load on command, count accepted input beats.
  always_comb begin
    in_cnt_d = in_cnt_q;
    if (cmd_fire_s && (cmd_len != '0)) begin
      in_cnt_d = cmd_len;
    end else if (i_val && i_rdy) begin
      in_cnt_d = in_cnt_q - ONE_BEAT;
    end else begin
      in_cnt_d = in_cnt_q;
    end
  end

  // Upstream budget register.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      in_cnt_q <= '0;
    end else begin
      in_cnt_q <= in_cnt_d;
    end
  end
`else
  // Pass-through: the host's ren is forwarded straight to the FIFO.
  assign out_val_s  = i_val & in_xfer_s & srst_n;
  assign i_rdy      = chnl_tx_data_ren & in_xfer_s & srst_n;
  assign out_data_s = i_data;
`endif

  assign chnl_tx_data       = out_data_s;
  assign chnl_tx_data_valid = out_val_s;
  assign out_fire_s         = out_val_s & chnl_tx_data_ren;

  // FSM next-state: the beat counter tracks host-side transfers only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_s && (cmd_len != '0)) begin
          len_d   = 32'(cmd_len) * WPB;
          cnt_d   = cmd_len;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (chnl_tx_ack) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_XFER: begin
        if (out_fire_s) begin
          cnt_d   = cnt_q - ONE_BEAT;
          state_d = (cnt_q == ONE_BEAT) ? ST_IDLE : ST_XFER;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, beat counter and latched channel length.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_chnl_tx_drain.sv
// tb_chnl_tx_drain: directed bench for chnl_tx_drain with a FIFO source model
// and a scoreboard of expected host beats. A second instance covers WIDTH=128.
module tb_chnl_tx_drain;

  logic        clk;
  logic        srst_n;
  logic        cmd_val, cmd_rdy;
  logic [15:0] cmd_len;
  logic        i_val, i_rdy;
  logic [31:0] i_data;
  logic        chnl_tx, chnl_tx_ack, chnl_tx_last;
  logic [31:0] chnl_tx_len;
  logic [30:0] chnl_tx_off;
  logic [31:0] chnl_tx_data;
  logic        chnl_tx_data_valid, chnl_tx_data_ren, busy;

  logic         b_srst_n, b_cmd_val, b_cmd_rdy, b_i_val, b_i_rdy;
  logic [15:0]  b_cmd_len;
  logic [127:0] b_i_data, b_tx_data;
  logic         b_tx, b_ack, b_last, b_valid, b_ren, b_busy;
  logic [31:0]  b_len;
  logic [30:0]  b_off;

  chnl_tx_drain #(.WIDTH(32), .LEN_W(16)) u_dut (
    .clk(clk), .srst_n(srst_n), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .cmd_len(cmd_len), .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data),
    .chnl_tx(chnl_tx), .chnl_tx_ack(chnl_tx_ack), .chnl_tx_last(chnl_tx_last),
    .chnl_tx_len(chnl_tx_len), .chnl_tx_off(chnl_tx_off),
    .chnl_tx_data(chnl_tx_data), .chnl_tx_data_valid(chnl_tx_data_valid),
    .chnl_tx_data_ren(chnl_tx_data_ren), .busy(busy)
  );

  chnl_tx_drain #(.WIDTH(128), .LEN_W(16)) u_dut128 (
    .clk(clk), .srst_n(b_srst_n), .cmd_val(b_cmd_val), .cmd_rdy(b_cmd_rdy),
    .cmd_len(b_cmd_len), .i_val(b_i_val), .i_rdy(b_i_rdy), .i_data(b_i_data),
    .chnl_tx(b_tx), .chnl_tx_ack(b_ack), .chnl_tx_last(b_last),
    .chnl_tx_len(b_len), .chnl_tx_off(b_off),
    .chnl_tx_data(b_tx_data), .chnl_tx_data_valid(b_valid),
    .chnl_tx_data_ren(b_ren), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] fifo[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int up_cnt = 0;
  int host_cnt = 0;
  bit gaps = 1'b0;
  bit stalls = 1'b0;
  int b_up = 0;
  int b_host = 0;
  logic [31:0] b_word = 32'd0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model drives head-of-queue; optional random gaps / host stalls.
  task automatic drive_inputs();
    i_val = (fifo.size() > 0) && !(gaps && ($urandom_range(0, 2) == 0));
    i_data = (fifo.size() > 0) ? fifo[0] : 32'd0;
    chnl_tx_data_ren = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
  endtask

  // One clock: observe handshakes away from the edge, step, redrive.
  task automatic cycle();
    logic [127:0] e;
    #1;
    if (i_val && i_rdy) begin
      up_cnt++;
      void'(fifo.pop_front());
    end
    if (chnl_tx_data_valid && chnl_tx_data_ren) begin
      host_cnt++;
      got_q.push_back(chnl_tx_data);
      e = (exp_q.size() > 0) ? {96'd0, exp_q.pop_front()} : {128{1'bx}};
      chk("host_beat", {96'd0, chnl_tx_data}, e);
    end
    @(posedge clk);
    @(negedge clk);
    drive_inputs();
  endtask

  task automatic send_cmd(input int len);
    chk("cmd_rdy_before_cmd", cmd_rdy, 1'b1);
    cmd_val = 1'b1;
    cmd_len = 16'(len);
    for (int i = 0; i < len && i < fifo.size(); i++) exp_q.push_back(fifo[i]);
    cycle();
    cmd_val = 1'b0;
    #1;
    if (len != 0) chk("chnl_tx_at_T1", chnl_tx, 1'b1);
  endtask

  task automatic do_ack(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      chk("req_no_i_rdy", i_rdy, 1'b0);
      chk("req_no_valid", chnl_tx_data_valid, 1'b0);
      cycle();
    end
    chnl_tx_ack = 1'b1;
    cycle();
    chnl_tx_ack = 1'b0;
  endtask

  task automatic run_xfer(input int n, input bit chk_busy);
    int start;
    int k;
    start = host_cnt;
    k = 0;
    while (host_cnt < start + n && k < 400) begin
      if (chk_busy) chk("busy_during_xfer", busy, 1'b1);
      cycle();
      k++;
    end
    chk("beats_delivered", 128'(host_cnt - start), 128'(n));
    chk("chnl_tx_low_after_last", chnl_tx, 1'b0);
    chk("cmd_rdy_after_last", cmd_rdy, 1'b1);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic b_cycle();
    #1;
    if (b_i_val && b_i_rdy) begin
      b_up++;
      b_word = b_word + 32'd1;
    end
    if (b_valid && b_ren) begin
      chk("w128_beat", b_tx_data, {4{32'(b_host)}});
      b_host++;
    end
    @(posedge clk);
    @(negedge clk);
    b_i_data = {4{b_word}};
    #1;
  endtask

  initial begin
    int k;
    srst_n = 1'b0; cmd_val = 1'b0; cmd_len = 16'd0; chnl_tx_ack = 1'b0;
    b_srst_n = 1'b0; b_cmd_val = 1'b0; b_cmd_len = 16'd0; b_ack = 1'b0;
    b_i_val = 1'b1; b_ren = 1'b1; b_i_data = 128'd0;
    @(negedge clk);
    drive_inputs();
    cycle();
    cycle();
    // Reset values.
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_chnl_tx", chnl_tx, 1'b0);
    chk("rst_len", chnl_tx_len, 32'd0);
    chk("rst_valid", chnl_tx_data_valid, 1'b0);
    chk("rst_i_rdy", i_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", chnl_tx_last, 1'b1);
    chk("rst_off", chnl_tx_off, 31'd0);
    chk("rst_data", chnl_tx_data, 32'd0);
    srst_n = 1'b1;
    b_srst_n = 1'b1;
    #1;
    chk("cmd_rdy_after_release", cmd_rdy, 1'b1);

    // Test 1: 4 of 8 preloaded beats, ack two cycles after request.
    for (int i = 0; i < 8; i++) fifo.push_back(32'h10 + 32'(i));
    drive_inputs();
    send_cmd(4);
    chk("t1_len", chnl_tx_len, 32'd4);
    do_ack(2);
`ifdef CHNL_TX_DRAIN_REG_EN
    chk("t1_first_beat_A1_reg", chnl_tx_data_valid, 1'b0);
    cycle();
    chk("t1_first_beat_A2_reg", chnl_tx_data_valid, 1'b1);
`else
    chk("t1_first_beat_A1", chnl_tx_data_valid, 1'b1);
`endif
    run_xfer(4, 1'b1);
    chk("t1_upstream_consumed", 128'(up_cnt), 128'd4);
    chk("t1_fifo_head", fifo[0], 32'h14);
    chk("t1_len_held", chnl_tx_len, 32'd4);

    // Test 2: zero-length command is a no-op.
    send_cmd(0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_cmd_rdy", cmd_rdy, 1'b1);
      chk("t2_chnl_tx", chnl_tx, 1'b0);
      chk("t2_i_rdy", i_rdy, 1'b0);
      cycle();
    end
    chk("t2_len_held", chnl_tx_len, 32'd4);

    // Test 3: 8 beats with random upstream gaps and host stalls.
    for (int i = 0; i < 12; i++) fifo.push_back(32'h30 + 32'(i));
    gaps = 1'b1;
    stalls = 1'b1;
    drive_inputs();
    send_cmd(8);
    chk("t3_len", chnl_tx_len, 32'd8);
    do_ack(1);
    run_xfer(8, 1'b1);
    gaps = 1'b0;
    stalls = 1'b0;
    drive_inputs();

    // Test 4: reset after 3 of 8 beats, then a 2-beat command.
    send_cmd(8);
    do_ack(0);
    k = host_cnt + 3;
    for (int i = 0; i < 50 && host_cnt < k; i++) cycle();
    chk("t4_three_beats", 128'(host_cnt), 128'(k));
    srst_n = 1'b0;
    chnl_tx_data_ren = 1'b0;
    cycle();
    chk("t4_chnl_tx_dropped", chnl_tx, 1'b0);
    chk("t4_busy_dropped", busy, 1'b0);
    chk("t4_cmd_rdy_in_rst", cmd_rdy, 1'b0);
    srst_n = 1'b1;
    #1;
    chk("t4_cmd_rdy_release", cmd_rdy, 1'b1);
    exp_q.delete();
    got_q.delete();
    drive_inputs();
    send_cmd(2);
    do_ack(1);
    run_xfer(2, 1'b1);
`ifndef CHNL_TX_DRAIN_REG_EN
    chk("t4_after_rst_beat0", got_q[0], 32'h37);
    chk("t4_after_rst_beat1", got_q[1], 32'h38);
`endif

    // Test 5: WIDTH=128, 3 beats -> length 12 words.
    b_cmd_val = 1'b1;
    b_cmd_len = 16'd3;
    b_cycle();
    b_cmd_val = 1'b0;
    chk("w128_len", b_len, 32'd12);
    chk("w128_chnl_tx", b_tx, 1'b1);
    b_ack = 1'b1;
    b_cycle();
    b_ack = 1'b0;
    for (int i = 0; i < 50 && b_host < 3; i++) b_cycle();
    b_cycle();
    chk("w128_beats", 128'(b_host), 128'd3);
    chk("w128_upstream", 128'(b_up), 128'd3);
    chk("w128_chnl_tx_low", b_tx, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
